// File: rtl/memory_stage.sv
// Memory-access stage: req/ack data-memory port with timeout abort, plus the M->W register.
// Optional misaligned-access check is enabled by defining MEM_MISALIGN_CHECK_EN.
module memory_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  ctrls_m,
  input  logic [31:0] aluout_m,
  input  logic [31:0] write_data_m,
  input  logic [4:0]  writereg_m,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall_m,
  output logic [1:0]  ctrls_w,
  output logic [31:0] aluout_w,
  output logic [31:0] readdata_w,
  output logic [4:0]  writereg_w,
  output logic        timeout_w
`ifdef MEM_MISALIGN_CHECK_EN
  ,
  output logic        misalign_w
`endif
);

  typedef enum logic {IDLE, WAIT} state_e;

  localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  ctrls_w_q, ctrls_w_d;
  logic [31:0] aluout_w_q, aluout_w_d;
  logic [31:0] readdata_w_q, readdata_w_d;
  logic [4:0]  writereg_w_q, writereg_w_d;
  logic        timeout_w_q, timeout_w_d;
  logic        misalign_w_q, misalign_w_d;

  logic access, is_store, is_load, misaligned, req_raw, abort;

  always_comb begin
    access   = ctrls_m[1] | ctrls_m[0];
    is_store = ctrls_m[0];
    is_load  = ctrls_m[1] & ~ctrls_m[0];
`ifdef MEM_MISALIGN_CHECK_EN
    misaligned = access & (aluout_m[1:0] != 2'b00);
`else
    misaligned = 1'b0;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_raw = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_raw = access & ~misaligned;
        if (req_raw && !dmem_ack) begin
          state_d = WAIT;
          cnt_d   = 8'd1;
        end
      end
      WAIT: begin
        req_raw = 1'b1;
        if (dmem_ack) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == TMO) begin
          // Request stays up during the abort cycle but no longer stalls.
          abort   = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    dmem_req   = req_raw & reset;
    stall_m    = dmem_req & ~dmem_ack & ~abort;
    dmem_we    = is_store;
    dmem_addr  = aluout_m;
    dmem_wdata = write_data_m;
  end

  always_comb begin
    ctrls_w_d    = ctrls_w_q;
    aluout_w_d   = aluout_w_q;
    readdata_w_d = readdata_w_q;
    writereg_w_d = writereg_w_q;
    timeout_w_d  = 1'b0;
    misalign_w_d = 1'b0;
    if (stall_m) begin
      ctrls_w_d = '0;
    end else begin
      ctrls_w_d    = {ctrls_m[2] & ~misaligned, ctrls_m[1]};
      aluout_w_d   = aluout_m;
      writereg_w_d = writereg_m;
      timeout_w_d  = abort;
      misalign_w_d = misaligned;
    end
    if (dmem_req && dmem_ack && is_load) begin
      readdata_w_d = dmem_rdata;
    end else if (abort && is_load) begin
      readdata_w_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ctrls_w_q    <= '0;
      aluout_w_q   <= '0;
      readdata_w_q <= '0;
      writereg_w_q <= '0;
      timeout_w_q  <= 1'b0;
      misalign_w_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ctrls_w_q    <= ctrls_w_d;
      aluout_w_q   <= aluout_w_d;
      readdata_w_q <= readdata_w_d;
      writereg_w_q <= writereg_w_d;
      timeout_w_q  <= timeout_w_d;
      misalign_w_q <= misalign_w_d;
    end
  end

  assign ctrls_w    = ctrls_w_q;
  assign aluout_w   = aluout_w_q;
  assign readdata_w = readdata_w_q;
  assign writereg_w = writereg_w_q;
  assign timeout_w  = timeout_w_q;
`ifdef MEM_MISALIGN_CHECK_EN
  assign misalign_w = misalign_w_q;
`else
  logic unused_misalign;
  assign unused_misalign = misalign_w_q;
`endif

endmodule

// File: tb/tb_memory_stage.sv
// Randomized self-checking bench for memory_stage against a transaction-level model
// (wait cycles = min(ack latency, timeout), abort when latency exceeds the timeout).
module tb_memory_stage;

  localparam int unsigned T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  ctrls_m;
  logic [31:0] aluout_m;
  logic [31:0] write_data_m;
  logic [4:0]  writereg_m;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        stall_m;
  logic [1:0]  ctrls_w;
  logic [31:0] aluout_w;
  logic [31:0] readdata_w;
  logic [4:0]  writereg_w;
  logic        timeout_w;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  logic [31:0] exp_rd  = '0;

  memory_stage #(.TIMEOUT_CYCLES(T)) dut (
    .clk          (clk),
    .reset        (reset),
    .ctrls_m      (ctrls_m),
    .aluout_m     (aluout_m),
    .write_data_m (write_data_m),
    .writereg_m   (writereg_m),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_ack     (dmem_ack),
    .dmem_rdata   (dmem_rdata),
    .stall_m      (stall_m),
    .ctrls_w      (ctrls_w),
    .aluout_w     (aluout_w),
    .readdata_w   (readdata_w),
    .writereg_w   (writereg_w),
    .timeout_w    (timeout_w)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One instruction through M: lat is the cycle index (0 = issue cycle) at which ack arrives.
  task automatic run_instr(input logic [2:0] ctrl, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [4:0] rg, input int unsigned lat, input logic [31:0] rd);
    bit          acc;
    bit          tmo;
    int unsigned waits;
    acc   = ctrl[1] | ctrl[0];
    tmo   = acc && (lat > T);
    waits = !acc ? 0 : (lat <= T ? lat : T);
    for (int unsigned c = 0; c <= waits; c++) begin
      @(negedge clk);
      ctrls_m      = ctrl;
      aluout_m     = addr;
      write_data_m = wd;
      writereg_m   = rg;
      dmem_ack     = acc ? (c == lat) : 1'($urandom_range(0, 1));
      dmem_rdata   = (acc && c == lat) ? rd : $urandom;
      #1;
      check("req", dmem_req, acc);
      check("stall", stall_m, acc && (c < waits));
      if (acc) begin
        check("we", dmem_we, ctrl[0]);
        check("addr", dmem_addr, addr);
        check("wdata", dmem_wdata, wd);
      end
      @(posedge clk);
      #1;
      if (c < waits) begin
        check("bubble_ctrls", ctrls_w, 2'b00);
        check("bubble_tmo", timeout_w, 1'b0);
      end
    end
    if (ctrl[1] && !ctrl[0]) exp_rd = tmo ? 32'h0 : rd;
    check("ctrls_w", ctrls_w, {ctrl[2], ctrl[1]});
    check("aluout_w", aluout_w, addr);
    check("writereg_w", writereg_w, rg);
    check("readdata_w", readdata_w, exp_rd);
    check("timeout_w", timeout_w, tmo);
  endtask

  initial begin
    reset        = 1'b0;
    ctrls_m      = '0;
    aluout_m     = '0;
    write_data_m = '0;
    writereg_m   = '0;
    dmem_ack     = 1'b0;
    dmem_rdata   = '0;
    #2;
    check("rst_req", dmem_req, 1'b0);
    check("rst_stall", stall_m, 1'b0);
    check("rst_ctrls", ctrls_w, 2'b00);
    check("rst_rd", readdata_w, 32'h0);
    check("rst_tmo", timeout_w, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    run_instr(3'b110, 32'h10, 32'h0, 5'd3, 0, 32'hCAFE0001);
    run_instr(3'b001, 32'h20, 32'h1234_5678, 5'd0, 3, 32'h0);
    run_instr(3'b110, 32'h30, 32'h0, 5'd7, 10, 32'hDEAD_BEEF);
    run_instr(3'b100, 32'h44, 32'h0, 5'd8, 0, 32'h0);
    run_instr(3'b011, 32'h48, 32'h5555_AAAA, 5'd9, 4, 32'h0);
    run_instr(3'b110, 32'h50, 32'h0, 5'd10, 1, 32'h0BAD_F00D);
    run_instr(3'b100, 32'h1234, 32'h0, 5'd11, 0, 32'h0);
    run_instr(3'b010, 32'h58, 32'h0, 5'd12, 4, 32'h7777_0000);

    // Reset during the second wait cycle of a load.
    @(negedge clk);
    ctrls_m  = 3'b110;
    aluout_m = 32'h60;
    dmem_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_req", dmem_req, 1'b0);
    check("mid_rst_stall", stall_m, 1'b0);
    check("mid_rst_ctrls", ctrls_w, 2'b00);
    check("mid_rst_alu", aluout_w, 32'h0);
    check("mid_rst_rd", readdata_w, 32'h0);
    check("mid_rst_wreg", writereg_w, 5'd0);
    check("mid_rst_tmo", timeout_w, 1'b0);
    exp_rd = '0;
    @(negedge clk);
    ctrls_m = 3'b000;
    reset   = 1'b1;
    run_instr(3'b110, 32'h64, 32'h0, 5'd4, 0, 32'h1357_9BDF);

    for (int i = 0; i < 200; i++) begin
      run_instr(3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom_range(0, 31)),
                $urandom_range(0, 6), $urandom);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
